// File: rtl/mem_wb_responder_pkg.sv
// Shared widths and FSM state encoding for the Jericalla MEM/WB responder.
package jericalla_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_wb_responder_if.sv
// EX/MEM -> MEM/WB bus: request side driven by the pipeline, write-back side by the responder.
interface mem_wb_responder_if;
  import jericalla_pkg::*;

  logic                  i_e_read_ram;
  logic                  i_e_write_ram;
  logic                  i_e_write_br;
  logic [REG_ADDR_W-1:0] i_wA;
  logic [DATA_W-1:0]     i_address;
  logic [DATA_W-1:0]     i_din_ram;
  logic [DATA_W-1:0]     i_dW;
  logic                  o_stall;
  logic                  o_e_write_br;
  logic [REG_ADDR_W-1:0] o_wA;
  logic [DATA_W-1:0]     o_dW;
  logic                  o_valid;
  logic                  o_err;

  modport slave (
    input  i_e_read_ram, i_e_write_ram, i_e_write_br, i_wA,
    input  i_address, i_din_ram, i_dW,
    output o_stall, o_e_write_br, o_wA, o_dW, o_valid, o_err
  );

  modport master (
    output i_e_read_ram, i_e_write_ram, i_e_write_br, i_wA,
    output i_address, i_din_ram, i_dW,
    input  o_stall, o_e_write_br, o_wA, o_dW, o_valid, o_err
  );

endinterface

// File: rtl/mem_wb_responder_data_ram.sv
// Single-port word RAM: synchronous write, combinational read, contents not reset.
module data_ram
  import jericalla_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout
);

  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];

  // Word write on the clock edge when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= din;
    end
  end

  assign dout = r_mem[addr];

endmodule

// File: rtl/mem_wb_responder.sv
// MEM stage responder: services loads/stores with LATENCY wait states and holds the MEM/WB register.
module mem_wb_responder
  import jericalla_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                clk,
  input  logic                rst,
  mem_wb_responder_if.slave   bus
);

  localparam logic [3:0] LAT = LATENCY[3:0];

  state_t                r_state, w_state_n;
  logic [3:0]            r_cnt, w_cnt_n;
  logic                  r_e_write_br, w_e_write_br_n;
  logic [REG_ADDR_W-1:0] r_wA, w_wA_n;
  logic [DATA_W-1:0]     r_dW, w_dW_n;
  logic                  r_valid, w_valid_n;
  logic                  r_err, w_err_n;

  logic                  w_any, w_req, w_misalign, w_oor, w_illegal, w_legal;
  logic                  w_complete, w_last_wait, w_ram_we;
  logic [DEPTH_LOG2-1:0] w_word;
  logic [DATA_W-1:0]     w_ram_dout;

  assign w_any      = bus.i_e_read_ram | bus.i_e_write_ram;
  assign w_req      = bus.i_e_read_ram ^ bus.i_e_write_ram;
  assign w_misalign = (bus.i_address[1:0] != 2'b00);
  assign w_oor      = ((bus.i_address >> (DEPTH_LOG2 + 2)) != '0);
  assign w_illegal  = (bus.i_e_read_ram & bus.i_e_write_ram) | (w_req & (w_misalign | w_oor));
  assign w_legal    = w_req & ~w_illegal;
  assign w_word     = bus.i_address[DEPTH_LOG2+1:2];
  assign w_last_wait = (r_state == BUSY) && (r_cnt == LAT);

  // Stall holds upstream until the completion cycle of a legal access
  assign bus.o_stall = w_legal && (LAT != 4'd0) && !w_last_wait;

  // Writes only land on the completion edge; reset suppresses a pending store
  assign w_ram_we = w_complete & bus.i_e_write_ram & ~rst;

  data_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .we   (w_ram_we),
    .addr (w_word),
    .din  (bus.i_din_ram),
    .dout (w_ram_dout)
  );

  // Next state, wait counter and MEM/WB payload; bubbles by default
  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = r_cnt;
    w_e_write_br_n = 1'b0;
    w_valid_n      = 1'b0;
    w_err_n        = 1'b0;
    w_wA_n         = r_wA;
    w_dW_n         = r_dW;
    w_complete     = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_illegal) begin
          w_err_n   = 1'b1;
          w_valid_n = 1'b1;
        end else if (!w_any) begin
          w_dW_n         = bus.i_dW;
          w_wA_n         = bus.i_wA;
          w_e_write_br_n = bus.i_e_write_br;
          w_valid_n      = 1'b1;
        end else if (LAT == 4'd0) begin
          w_complete = 1'b1;
        end else begin
          w_state_n = BUSY;
          w_cnt_n   = 4'd1;
        end
      end
      BUSY: begin
        if (r_cnt == LAT) begin
          w_complete = 1'b1;
          w_state_n  = IDLE;
          w_cnt_n    = 4'd0;
        end else begin
          w_cnt_n = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_n = IDLE;
        w_cnt_n   = 4'd0;
      end
    endcase

    // Loads capture the pre-edge RAM word; stores keep the previous o_dW
    if (w_complete) begin
      w_e_write_br_n = bus.i_e_write_br;
      w_wA_n         = bus.i_wA;
      w_valid_n      = 1'b1;
      if (bus.i_e_read_ram) begin
        w_dW_n = w_ram_dout;
      end
    end
  end

  // State, counter and MEM/WB registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_e_write_br <= 1'b0;
      r_wA         <= '0;
      r_dW         <= '0;
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_e_write_br <= w_e_write_br_n;
      r_wA         <= w_wA_n;
      r_dW         <= w_dW_n;
      r_valid      <= w_valid_n;
      r_err        <= w_err_n;
    end
  end

  assign bus.o_e_write_br = r_e_write_br;
  assign bus.o_wA         = r_wA;
  assign bus.o_dW         = r_dW;
  assign bus.o_valid      = r_valid;
  assign bus.o_err        = r_err;

endmodule

// File: tb/tb_mem_wb_responder.sv
// Directed bench: one responder with LATENCY=2 and one with LATENCY=0.
module tb_mem_wb_responder;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_wb_responder_if bus_a ();
  mem_wb_responder_if bus_b ();

  mem_wb_responder #(.DEPTH_LOG2(8), .LATENCY(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  mem_wb_responder #(.DEPTH_LOG2(8), .LATENCY(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.i_e_read_ram  = 1'b0;
    bus_a.i_e_write_ram = 1'b0;
    bus_a.i_e_write_br  = 1'b0;
    bus_a.i_wA          = 5'd0;
    bus_a.i_address     = 32'h0;
    bus_a.i_din_ram     = 32'h0;
    bus_a.i_dW          = 32'h0;
  endtask

  task automatic idle_b();
    bus_b.i_e_read_ram  = 1'b0;
    bus_b.i_e_write_ram = 1'b0;
    bus_b.i_e_write_br  = 1'b0;
    bus_b.i_wA          = 5'd0;
    bus_b.i_address     = 32'h0;
    bus_b.i_din_ram     = 32'h0;
    bus_b.i_dW          = 32'h0;
  endtask

  task automatic store_a(input logic [31:0] addr, input logic [31:0] data);
    idle_a();
    bus_a.i_e_write_ram = 1'b1;
    bus_a.i_address     = addr;
    bus_a.i_din_ram     = data;
  endtask

  task automatic load_a(input logic [31:0] addr, input logic [4:0] wa);
    idle_a();
    bus_a.i_e_read_ram = 1'b1;
    bus_a.i_e_write_br = 1'b1;
    bus_a.i_address    = addr;
    bus_a.i_wA         = wa;
    bus_a.i_dW         = 32'h0000_0055;
  endtask

  logic [31:0] vals [4] = '{32'h0000_0001, 32'hA5A5_5A5A, 32'hFFFF_0000, 32'h1357_9BDF};

  initial begin
    rst = 1'b1;
    idle_a();
    idle_b();
    tick();
    tick();

    // Reset state
    chk("rst_stall",  {31'd0, bus_a.o_stall},      32'd0);
    chk("rst_web",    {31'd0, bus_a.o_e_write_br}, 32'd0);
    chk("rst_wA",     {27'd0, bus_a.o_wA},         32'd0);
    chk("rst_dW",     bus_a.o_dW,                  32'd0);
    chk("rst_valid",  {31'd0, bus_a.o_valid},      32'd0);
    chk("rst_err",    {31'd0, bus_a.o_err},        32'd0);
    chk("rst_b_valid",{31'd0, bus_b.o_valid},      32'd0);
    rst = 1'b0;

    // Passthrough retire
    bus_a.i_dW = 32'h1234; bus_a.i_wA = 5'd7; bus_a.i_e_write_br = 1'b1;
    #1 chk("pt_stall", {31'd0, bus_a.o_stall}, 32'd0);
    tick();
    chk("pt_dW",    bus_a.o_dW,                  32'h1234);
    chk("pt_wA",    {27'd0, bus_a.o_wA},         32'd7);
    chk("pt_web",   {31'd0, bus_a.o_e_write_br}, 32'd1);
    chk("pt_valid", {31'd0, bus_a.o_valid},      32'd1);

    // Store 0xDEADBEEF to 0x10 with two wait states
    store_a(32'h10, 32'hDEAD_BEEF);
    #1 chk("st_stall0", {31'd0, bus_a.o_stall}, 32'd1);
    tick();
    chk("st_valid1", {31'd0, bus_a.o_valid},      32'd0);
    chk("st_web1",   {31'd0, bus_a.o_e_write_br}, 32'd0);
    chk("st_stall1", {31'd0, bus_a.o_stall},      32'd1);
    tick();
    chk("st_valid2", {31'd0, bus_a.o_valid}, 32'd0);
    chk("st_stall2", {31'd0, bus_a.o_stall}, 32'd0);
    tick();
    chk("st_valid3", {31'd0, bus_a.o_valid},      32'd1);
    chk("st_web3",   {31'd0, bus_a.o_e_write_br}, 32'd0);

    // Back-to-back load from 0x10
    load_a(32'h10, 5'd3);
    #1 chk("ld_stall0", {31'd0, bus_a.o_stall}, 32'd1);
    tick();
    chk("ld_valid1", {31'd0, bus_a.o_valid}, 32'd0);
    tick();
    chk("ld_stall2", {31'd0, bus_a.o_stall}, 32'd0);
    tick();
    chk("ld_dW",    bus_a.o_dW,                  32'hDEAD_BEEF);
    chk("ld_wA",    {27'd0, bus_a.o_wA},         32'd3);
    chk("ld_web",   {31'd0, bus_a.o_e_write_br}, 32'd1);
    chk("ld_valid", {31'd0, bus_a.o_valid},      32'd1);

    // Misaligned load
    load_a(32'h13, 5'd9);
    #1 chk("mis_stall", {31'd0, bus_a.o_stall}, 32'd0);
    tick();
    chk("mis_err",   {31'd0, bus_a.o_err},        32'd1);
    chk("mis_web",   {31'd0, bus_a.o_e_write_br}, 32'd0);
    chk("mis_valid", {31'd0, bus_a.o_valid},      32'd1);
    idle_a();
    tick();
    chk("mis_err_clr", {31'd0, bus_a.o_err}, 32'd0);

    // Both enables high: must not write RAM
    idle_a();
    bus_a.i_e_read_ram = 1'b1; bus_a.i_e_write_ram = 1'b1; bus_a.i_e_write_br = 1'b1;
    bus_a.i_address = 32'h10; bus_a.i_din_ram = 32'h0BAD_BAD0;
    #1 chk("both_stall", {31'd0, bus_a.o_stall}, 32'd0);
    tick();
    chk("both_err", {31'd0, bus_a.o_err},        32'd1);
    chk("both_web", {31'd0, bus_a.o_e_write_br}, 32'd0);

    // Out-of-range load at 0x400
    load_a(32'h400, 5'd4);
    #1 chk("oor_stall", {31'd0, bus_a.o_stall}, 32'd0);
    tick();
    chk("oor_err", {31'd0, bus_a.o_err}, 32'd1);

    // RAM at 0x10 unchanged by the illegal accesses
    load_a(32'h10, 5'd5);
    tick(); tick(); tick();
    chk("ram_keep", bus_a.o_dW, 32'hDEAD_BEEF);

    // Reset during the second BUSY cycle of a store
    store_a(32'h20, 32'h1111_2222);
    tick(); tick(); tick();
    store_a(32'h20, 32'hCAFE_F00D);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_valid", {31'd0, bus_a.o_valid},      32'd0);
    chk("mrst_dW",    bus_a.o_dW,                  32'd0);
    chk("mrst_web",   {31'd0, bus_a.o_e_write_br}, 32'd0);
    idle_a();
    #1 chk("mrst_stall", {31'd0, bus_a.o_stall}, 32'd0);
    tick();
    rst = 1'b0;
    chk("mrst_valid2", {31'd0, bus_a.o_valid}, 32'd0);
    load_a(32'h20, 5'd6);
    tick(); tick(); tick();
    chk("mrst_ram", bus_a.o_dW, 32'h1111_2222);
    idle_a();

    // Zero-latency alternating store/load to 0x8
    for (int unsigned k = 0; k < 4; k++) begin
      idle_b();
      bus_b.i_e_write_ram = 1'b1;
      bus_b.i_address     = 32'h8;
      bus_b.i_din_ram     = vals[k];
      #1 chk("z_st_stall", {31'd0, bus_b.o_stall}, 32'd0);
      tick();
      chk("z_st_valid", {31'd0, bus_b.o_valid}, 32'd1);
      idle_b();
      bus_b.i_e_read_ram = 1'b1;
      bus_b.i_e_write_br = 1'b1;
      bus_b.i_address    = 32'h8;
      bus_b.i_wA         = 5'(k + 10);
      #1 chk("z_ld_stall", {31'd0, bus_b.o_stall}, 32'd0);
      tick();
      chk("z_ld_dW", bus_b.o_dW,          vals[k]);
      chk("z_ld_wA", {27'd0, bus_b.o_wA}, k + 10);
    end
    idle_b();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
